// File: rtl/piano_tone_seq.sv
// Key-triggered square-wave tone generator for a passive buzzer.
// Rising key edge picks a note (lowest index wins); note plays for NOTE_CYCLES, optionally sustained.
module piano_tone_seq #(
  parameter int NUM_KEYS    = 8,
  parameter int CNT_W       = 24,
  parameter logic [NUM_KEYS*CNT_W-1:0] HALF_TABLE = {
    24'd47809, 24'd50618, 24'd56817, 24'd63774,
    24'd71632, 24'd75756, 24'd85033, 24'd95419},
  parameter int DUR_W       = 32,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                sustain_en,
  output logic                beep_out,
  output logic                note_valid,
  output logic [IDX_W-1:0]    note_idx
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(NOTE_CYCLES - 1);

  state_t                state;
  logic [NUM_KEYS-1:0]   keys_d;
  logic [NUM_KEYS-1:0]   rise;
  logic [IDX_W-1:0]      sel;
  logic                  new_press;
  logic [CNT_W-1:0]      tone_cnt;
  logic [DUR_W-1:0]      dur_cnt;
  logic [CNT_W-1:0]      half_tab [NUM_KEYS];
  logic [CNT_W-1:0]      half;
  logic                  hold;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_tab
    assign half_tab[i] = HALF_TABLE[i*CNT_W +: CNT_W];
  end

  assign rise      = keys & ~keys_d;
  assign new_press = |rise;
  assign half      = half_tab[note_idx];
  assign hold      = sustain_en && keys[note_idx];

  // Scan high-to-low so the lowest rising index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (rise[i]) sel = IDX_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      keys_d     <= '1;
      beep_out   <= 1'b0;
      note_valid <= 1'b0;
      note_idx   <= '0;
      tone_cnt   <= '0;
      dur_cnt    <= '0;
    end else begin
      keys_d <= keys;
      if (new_press) begin
        state      <= PLAY;
        note_valid <= 1'b1;
        note_idx   <= sel;
        tone_cnt   <= '0;
        dur_cnt    <= '0;
        beep_out   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            beep_out <= 1'b0;
          end
          PLAY: begin
            if (!hold && dur_cnt == DUR_LAST) begin
              state      <= IDLE;
              note_valid <= 1'b0;
              note_idx   <= '0;
              beep_out   <= 1'b0;
              tone_cnt   <= '0;
              dur_cnt    <= '0;
            end else begin
              if (tone_cnt == half) begin
                tone_cnt <= '0;
                beep_out <= ~beep_out;
              end else begin
                tone_cnt <= tone_cnt + 1'b1;
              end
              dur_cnt <= hold ? '0 : dur_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
